// File: rtl/axis_uart_tx.sv
// rtl/axis_uart_tx.sv - AXI-stream sink that serializes words onto an async serial line
module axis_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [DATA_BITS-1:0] idata,
    input  logic                 ivalid,
    output logic                 iready,
    output logic                 txd,
    output logic                 busy
);

    localparam int TW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BMAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] D_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state, state_next;
    logic [TW-1:0]         timer, timer_next;
    logic [BW-1:0]         bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0]  shreg, shreg_next, shreg_shifted;
    logic                  txd_next;
    logic                  bit_end;
    logic                  accept;

    assign bit_end       = (timer == T_LAST);
    assign shreg_shifted = shreg >> 1;

    // Ready only while idle or in the very last cycle of the last stop bit, so
    // a waiting word can start the next frame with no gap on the line.
    assign iready = (state == IDLE) || ((state == STOP) && bit_end && (bit_cnt == S_LAST));
    assign accept = ivalid && iready;
    assign busy   = (state != IDLE);

    // State, timers, shift register and the registered line output.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
            txd     <= txd_next;
        end
    end

    // Next-state logic; txd_next is the line level for the cycle after the edge.
    always_comb begin
        state_next   = state;
        timer_next   = bit_end ? '0 : timer + TW'(1);
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        txd_next     = txd;
        case (state)
            IDLE: begin
                timer_next   = '0;
                bit_cnt_next = '0;
                txd_next     = 1'b1;
                if (accept) begin
                    state_next = START;
                    shreg_next = idata;
                    txd_next   = 1'b0;
                end
            end
            START: begin
                txd_next = 1'b0;
                if (bit_end) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    txd_next     = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == D_LAST) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                        txd_next     = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                        shreg_next   = shreg_shifted;
                        txd_next     = shreg_shifted[0];
                    end
                end
            end
            STOP: begin
                txd_next = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == S_LAST) begin
                        bit_cnt_next = '0;
                        if (accept) begin
                            state_next = START;
                            shreg_next = idata;
                            txd_next   = 1'b0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + BW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_uart_tx.sv
// tb/tb_axis_uart_tx.sv - self-checking bench for axis_uart_tx (1 and 2 stop bits)
module tb_axis_uart_tx;

    localparam int C = 4;
    localparam int D = 8;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] idata [2];
    logic       ivalid [2];
    logic       iready [2];
    logic       txd [2];
    logic       busy [2];

    always #5 clock = ~clock;

    axis_uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(D), .STOP_BITS(1)) dut0 (
        .clock  (clock),
        .resetn (resetn),
        .idata  (idata[0]),
        .ivalid (ivalid[0]),
        .iready (iready[0]),
        .txd    (txd[0]),
        .busy   (busy[0])
    );

    axis_uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(D), .STOP_BITS(2)) dut1 (
        .clock  (clock),
        .resetn (resetn),
        .idata  (idata[1]),
        .ivalid (ivalid[1]),
        .iready (iready[1]),
        .txd    (txd[1]),
        .busy   (busy[1])
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         m_act [2];
    int         m_t [2];
    logic [7:0] m_word [2];
    int         hs_cnt [2];

    // Reference model: a frame is a list of bit slots {start, data LSB first, stops},
    // each C cycles long, indexed by cycles elapsed since the accepting edge.
    function automatic int frame_len(int i);
        return (1 + D + ((i == 0) ? 1 : 2)) * C;
    endfunction

    function automatic logic exp_txd(int i);
        int slot;
        if (!m_act[i]) return 1'b1;
        slot = m_t[i] / C;
        if (slot == 0) return 1'b0;
        if (slot <= D) return m_word[i][slot-1];
        return 1'b1;
    endfunction

    function automatic logic exp_ready(int i);
        return !m_act[i] || (m_t[i] == frame_len(i) - 1);
    endfunction

    task automatic check(input string tag, input int i, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s[dut%0d] cycle=%0d observed=%b expected=%b", tag, i, cyc, obs, exp);
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check("txd", i, txd[i], exp_txd(i));
            check("busy", i, busy[i], m_act[i]);
            check("iready", i, iready[i], exp_ready(i));
        end
    endtask

    // One clock: check outputs away from the edge, drive inputs, advance the model.
    task automatic step(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1);
        @(negedge clock);
        check_all();
        ivalid[0] = v0; idata[0] = d0;
        ivalid[1] = v1; idata[1] = d1;
        for (int i = 0; i < 2; i++) begin
            if (ivalid[i] && exp_ready(i)) begin
                m_act[i]  = 1'b1;
                m_t[i]    = 0;
                m_word[i] = idata[i];
                hs_cnt[i]++;
            end else if (m_act[i]) begin
                m_t[i]++;
                if (m_t[i] == frame_len(i)) m_act[i] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        #2;
        ivalid[0] = 1'b0;
        ivalid[1] = 1'b0;
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) m_act[i] = 1'b0;
        #1;
        check_all();
        repeat (3) begin
            @(negedge clock);
            check_all();
        end
        resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            idata[i] = 8'h00; ivalid[i] = 1'b0;
            m_act[i] = 1'b0; m_t[i] = 0; m_word[i] = 8'h00; hs_cnt[i] = 0;
        end

        // Reset then idle: line stays high, always ready.
        @(negedge clock);
        do_reset();
        repeat (20) step(1'b0, 8'h00, 1'b0, 8'h00);

        // Single words, then junk on the inputs while the frame is in flight.
        step(1'b1, 8'hA5, 1'b1, 8'h81);
        for (int c = 0; c < 30; c++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
        repeat (20) step(1'b0, 8'h00, 1'b0, 8'h00);

        // Back-to-back: 0x00 then 0xFF with ivalid held high.
        begin
            int h0;
            h0 = hs_cnt[0];
            for (int c = 0; c < 200 && hs_cnt[0] < h0 + 2; c++)
                step(1'b1, (hs_cnt[0] == h0) ? 8'h00 : 8'hFF, 1'b1, 8'h81);
            check("b2b_accepts", 0, 1'(hs_cnt[0] >= h0 + 2), 1'b1);
            for (int c = 0; c < 3 * 44; c++) step(1'b0, 8'hFF, 1'b1, 8'h81);
            repeat (50) step(1'b0, 8'h00, 1'b0, 8'h00);
        end

        // Reset during data bit 3 (cycles 16..19 of the frame), then a clean 0x3C.
        step(1'b1, 8'h5A, 1'b1, 8'h5A);
        for (int c = 0; c < 100 && m_t[0] < 17; c++) step(1'b0, 8'h00, 1'b0, 8'h00);
        check("reached_bit3", 0, 1'(m_act[0] && m_t[0] == 17), 1'b1);
        do_reset();
        step(1'b1, 8'h3C, 1'b1, 8'h3C);
        repeat (50) step(1'b0, 8'h00, 1'b0, 8'h00);

        // Random traffic.
        for (int c = 0; c < 600; c++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
        repeat (50) step(1'b0, 8'h00, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
